window_line_buffer: RTL
=======================

WINDOW_LINE_BUFFER -- requirements
Module: window_line_buffer

Interface
REQ-001 SHALL provide parameter WIDTH, default 12, pixel data width in bits.
REQ-002 SHALL provide parameter MAX_LINE, default 640, maximum pixels per line (RAM depth per row).
REQ-003 SHALL provide parameter TAPS, default 3, number of vertically aligned rows output (≥2).
REQ-004 SHALL provide parameter CW, default $clog2(MAX_LINE)+1, width of line-length and column fields.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  pixel strobe; din/iEdge/sof sampled only when high.
REQ-008 sof  in  1  start of frame; qualifies first pixel of frame (with enable).
REQ-009 line_len  in  CW  runtime line length, sampled on enable&&sof.
REQ-010 din  in  WIDTH  incoming pixel.
REQ-011 iEdge  in  1  edge flag carried with pixel.
REQ-012 taps  out  TAPS*WIDTH  column window; slice k = pixel k lines older than newest, k=0 in LSBs.
REQ-013 oEdge  out  1  edge flag of the pixel on slice (TAPS-1)/2 (centre row).
REQ-014 valid  out  1  one-cycle strobe; taps hold a fully populated column.
REQ-015 col  out  CW  column index of the pixel currently on taps.

Function
REQ-016 SHALL store TAPS-1 previous lines in circular row buffers (RAM-inferable, WIDTH+1 bits/entry incl. edge flag), not a flat shift register.
REQ-017 SHALL maintain column counter: increments per enable; wraps to 0 after active_len-1.
REQ-018 SHALL maintain line counter: increments on column wrap, saturates at TAPS-1.
REQ-019 On enable&&sof: column and line counters forced to 0, active_len latched, current pixel written at column 0 of the new frame.
REQ-020 active_len SHALL equal line_len, except line_len==0 or line_len>MAX_LINE SHALL latch MAX_LINE.
REQ-021 Latency SHALL be exactly 1 cycle: pixel accepted at cycle n appears on taps slice 0 at n+1, with slices 1..TAPS-1 = same-column pixels from 1..TAPS-1 lines earlier.
REQ-022 Per accepted pixel SHALL read old column entries and write new entries in the same cycle (read-before-write), row k receiving row k-1's old value.
REQ-023 valid SHALL be asserted at n+1 iff enable at n and line counter (before that pixel's wrap update) ≥ TAPS-1.
REQ-024 With enable low: no state change; taps, oEdge, col hold; valid 0.
REQ-025 sof without enable SHALL be ignored.
REQ-026 line_len changes not accompanied by enable&&sof SHALL have no effect.
REQ-027 Stale RAM contents from previous frame SHALL never produce valid=1 before TAPS-1 complete lines of the new frame.
REQ-028 Back-to-back enable every cycle SHALL be sustained with no bubbles.
REQ-029 col output SHALL equal column counter value used for that pixel (0..active_len-1).

Reset
REQ-030 On rst low: taps=0, oEdge=0, valid=0, col=0, counters=0, active_len=MAX_LINE; RAM contents need not be cleared.
REQ-031 Reset asserted mid-line SHALL abandon the frame; after release valid stays 0 until TAPS-1 full lines accepted.
REQ-032 First enable after reset without sof SHALL be treated as column 0, line 0.

Verification
REQ-033 TAPS=3, sof+line_len=4, stream pixels 0..15 continuous -> valid first at pixel 8 (cycle after), taps={0,4,8} for slices {2,1,0}, col=0; pixel 11 -> {3,7,11}, col=3.
REQ-034 Same stream with enable toggling 1/0 each cycle -> identical tap/valid sequence, valid only after enable cycles, outputs held in gaps.
REQ-035 line_len=0 at sof -> wrap at 639 (MAX_LINE); line_len=700 -> also 639.
REQ-036 Second sof after 2.5 lines of frame 1 -> valid stays 0 for first 8 pixels of frame 2 (line_len=4), no frame-1 data with valid=1.
REQ-037 iEdge=1 only on pixel 5 (line_len=4) -> oEdge=1 exactly when pixel 5 on slice 1, i.e. after pixel 9 accepted.
REQ-038 rst pulse low mid-line 2 -> all outputs 0 immediately; resume without sof -> col restarts at 0, valid after 2 full lines.

Source files
------------

// File: rtl/window_line_buffer.sv
// Vertical column window over a raster stream: TAPS-1 circular row RAMs plus the
// live pixel give TAPS same-column pixels per accepted input, one cycle later.
module window_line_buffer #(
  parameter int WIDTH    = 12,
  parameter int MAX_LINE = 640,
  parameter int TAPS     = 3,
  parameter int CW       = $clog2(MAX_LINE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sof,
  input  logic [CW-1:0]         line_len,
  input  logic [WIDTH-1:0]      din,
  input  logic                  iEdge,
  output logic [TAPS*WIDTH-1:0] taps,
  output logic                  oEdge,
  output logic                  valid,
  output logic [CW-1:0]         col
);

  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int LW = $clog2(TAPS) + 1;
  localparam logic [LW-1:0] LINE_FULL = LW'(TAPS - 1);
  localparam logic [CW-1:0] MAX_LEN   = CW'(MAX_LINE);
  localparam int CENTRE = (TAPS - 1) / 2;

  logic [CW-1:0]         col_r, active_len_r;
  logic [LW-1:0]         line_r;
  logic [CW-1:0]         col_s, len_s, col_nxt_s;
  logic [LW-1:0]         line_s, line_nxt_s;
  logic [AW-1:0]         addr_s;
  logic [WIDTH:0]        rd_s  [TAPS-1];
  logic [WIDTH:0]        win_s [TAPS];
  logic [TAPS*WIDTH-1:0] taps_nxt_s;

  // Counter values for the pixel being accepted; sof restarts the frame in-cycle
  always_comb begin
    col_s      = col_r;
    line_s     = line_r;
    len_s      = active_len_r;
    col_nxt_s  = col_r;
    line_nxt_s = line_r;
    if (sof) begin
      col_s  = '0;
      line_s = '0;
      if ((line_len == '0) || (line_len > MAX_LEN)) begin
        len_s = MAX_LEN;
      end else begin
        len_s = line_len;
      end
    end else begin
      col_s  = col_r;
      line_s = line_r;
      len_s  = active_len_r;
    end
    if (col_s == (len_s - CW'(1))) begin
      col_nxt_s = '0;
      if (line_s == LINE_FULL) begin
        line_nxt_s = line_s;
      end else begin
        line_nxt_s = line_s + LW'(1);
      end
    end else begin
      col_nxt_s  = col_s + CW'(1);
      line_nxt_s = line_s;
    end
    addr_s = col_s[AW-1:0];
  end

  // Row k of each column is written with row k-1's pre-write contents (read-before-write)
  for (genvar k = 0; k < TAPS - 1; k++) begin : g_row
    logic [WIDTH:0] mem_r [MAX_LINE];
    logic [WIDTH:0] wr_s;
    if (k == 0) begin : g_first
      assign wr_s = {iEdge, din};
    end else begin : g_next
      assign wr_s = rd_s[k-1];
    end
    assign rd_s[k] = mem_r[addr_s];

    // Row storage, no reset so it maps onto RAM
    always_ff @(posedge clk) begin
      if (enable) begin
        mem_r[addr_s] <= wr_s;
      end
    end
  end

  // Assemble the next column window: live pixel on slice 0, older rows above it
  always_comb begin
    taps_nxt_s = '0;
    win_s[0]   = {iEdge, din};
    for (int k = 1; k < TAPS; k++) begin
      win_s[k] = rd_s[k-1];
    end
    for (int k = 0; k < TAPS; k++) begin
      taps_nxt_s[k*WIDTH +: WIDTH] = win_s[k][WIDTH-1:0];
    end
  end

  // Counters and registered outputs; valid only once TAPS-1 lines of this frame exist
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_r        <= '0;
      line_r       <= '0;
      active_len_r <= MAX_LEN;
      taps         <= '0;
      oEdge        <= 1'b0;
      valid        <= 1'b0;
      col          <= '0;
    end else if (enable) begin
      col_r        <= col_nxt_s;
      line_r       <= line_nxt_s;
      active_len_r <= len_s;
      taps         <= taps_nxt_s;
      oEdge        <= win_s[CENTRE][WIDTH];
      valid        <= (line_s == LINE_FULL);
      col          <= col_s;
    end else begin
      valid        <= 1'b0;
    end
  end

endmodule
